// File: rtl/h264_nal_parser.sv
// H.264 Annex-B NAL parser: 16-bit words enter an input FIFO, are unpacked
// into bytes, start codes and trailing zeros are removed, and NAL bytes leave
// through a valid/ready byte port with start/end flags.
// Optional feature macro: H264_NAL_EPB_STRIP_EN (drop emulation-prevention 0x03).
module h264_nal_parser #(
    parameter int g_FIFO_AW = 4,
    parameter int g_CNT_W   = 16
) (
    input  logic               PIX_CLK,
    input  logic               RESET_N,
    input  logic               DATA_VALID_I,
    input  logic [15:0]        DATA_I,
    input  logic               FLUSH_I,
    input  logic               BYTE_READY_I,
    output logic               BYTE_VALID_O,
    output logic [7:0]         BYTE_O,
    output logic               NAL_START_O,
    output logic               NAL_END_O,
    output logic [4:0]         NAL_TYPE_O,
    output logic [g_CNT_W-1:0] NAL_COUNT_O,
    output logic               OVERFLOW_O
);
    localparam int DEPTH = 2 ** g_FIFO_AW;
    localparam logic [g_FIFO_AW:0] PTR_ONE = 1;
    localparam logic [g_CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {ST_HUNT, ST_HEADER, ST_PAYLOAD} state_t;

    // input FIFO: entry = {has_data, flush, data}
    logic [17:0]        mem [DEPTH];
    logic [g_FIFO_AW:0] wr_ptr_reg, rd_ptr_reg;
    logic               fifo_empty, fifo_full, fifo_wr, pop;

    // unpacker: current entry and which part of it is next
    logic [17:0] ent_reg;
    logic        ent_valid_reg;
    logic [1:0]  phase_reg;
    logic [7:0]  cur_byte;
    logic        cur_flush, last_step, ent_done;

    // detector / release / output path
    state_t      state_reg, state_next;
    logic [1:0]  zero_run_reg, zero_run_next;
    logic [1:0]  held_reg, held_next;
    logic        rel_reg, rel_next;
    logic        pend_valid_reg, pend_valid_next;
    logic [7:0]  pend_byte_reg, pend_byte_next;
    logic        last_valid_reg, last_valid_next;
    logic [7:0]  last_byte_reg, last_byte_next;
    logic        last_start_reg, last_start_next;
    logic        out_valid_reg, out_valid_next;
    logic [7:0]  out_byte_reg, out_byte_next;
    logic        out_start_reg, out_start_next;
    logic        out_end_reg, out_end_next;
    logic [4:0]  type_reg, type_next;
    logic [g_CNT_W-1:0] count_reg;
    logic        overflow_reg;
    logic        out_free, det_fire, rel_step;
    logic        do_push, push_start, do_term;
    logic [7:0]  push_byte;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[g_FIFO_AW] != rd_ptr_reg[g_FIFO_AW]) &&
                        (wr_ptr_reg[g_FIFO_AW-1:0] == rd_ptr_reg[g_FIFO_AW-1:0]);
    assign fifo_wr    = DATA_VALID_I || FLUSH_I;

    // the output register may take a new byte when empty or being accepted now
    assign out_free  = !out_valid_reg || BYTE_READY_I;
    assign det_fire  = ent_valid_reg && out_free && !rel_reg;
    assign rel_step  = out_free && rel_reg;

    assign cur_byte  = (phase_reg == 2'd0) ? ent_reg[15:8] : ent_reg[7:0];
    assign cur_flush = !ent_reg[17] || (phase_reg == 2'd2);
    assign last_step = cur_flush || ((phase_reg == 2'd1) && !ent_reg[16]);
    assign ent_done  = det_fire && last_step;
    assign pop       = !fifo_empty && (!ent_valid_reg || ent_done);

    // RAM write port and registered read into the unpacker entry
    always_ff @(posedge PIX_CLK) begin
        if (fifo_wr && !fifo_full)
            mem[wr_ptr_reg[g_FIFO_AW-1:0]] <= {DATA_VALID_I, FLUSH_I, DATA_I};
        if (pop)
            ent_reg <= mem[rd_ptr_reg[g_FIFO_AW-1:0]];
    end

    // FIFO pointers, overflow flag and unpacker sequencing
    always_ff @(posedge PIX_CLK) begin
        if (!RESET_N) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            overflow_reg  <= 1'b0;
            ent_valid_reg <= 1'b0;
            phase_reg     <= 2'd0;
        end else begin
            if (fifo_wr) begin
                if (fifo_full) overflow_reg <= 1'b1;
                else           wr_ptr_reg   <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg    <= rd_ptr_reg + PTR_ONE;
                ent_valid_reg <= 1'b1;
                phase_reg     <= 2'd0;
            end else if (ent_done) begin
                ent_valid_reg <= 1'b0;
            end else if (det_fire) begin
                phase_reg     <= phase_reg + 2'd1;
            end
        end
    end

    // state register of the start-code FSM
    always_ff @(posedge PIX_CLK) begin
        if (!RESET_N) state_reg <= ST_HUNT;
        else          state_reg <= state_next;
    end

    // next-state, zero tracking, held-zero release and output path
    always_comb begin
        state_next      = state_reg;
        zero_run_next   = zero_run_reg;
        held_next       = held_reg;
        rel_next        = rel_reg;
        pend_valid_next = pend_valid_reg;
        pend_byte_next  = pend_byte_reg;
        type_next       = type_reg;
        do_push         = 1'b0;
        push_byte       = 8'h00;
        push_start      = 1'b0;
        do_term         = 1'b0;
        if (rel_step) begin
            if (held_reg != 2'd0) begin
                do_push   = 1'b1;
                held_next = held_reg - 2'd1;
                if (held_reg == 2'd1 && !pend_valid_reg) rel_next = 1'b0;
            end else begin
                do_push         = pend_valid_reg;
                push_byte       = pend_byte_reg;
                pend_valid_next = 1'b0;
                rel_next        = 1'b0;
            end
        end else if (det_fire) begin
            if (cur_flush) begin
                do_term       = 1'b1;
                held_next     = 2'd0;
                zero_run_next = 2'd0;
                state_next    = ST_HUNT;
            end else if (cur_byte == 8'h01 && zero_run_reg >= 2'd2) begin
                do_term       = 1'b1;
                held_next     = 2'd0;
                zero_run_next = 2'd0;
                state_next    = ST_HEADER;
            end else begin
                if (cur_byte == 8'h00)
                    zero_run_next = (zero_run_reg == 2'd3) ? 2'd3 : zero_run_reg + 2'd1;
                else
                    zero_run_next = 2'd0;
                case (state_reg)
                    ST_HEADER: begin
                        do_push    = 1'b1;
                        push_byte  = cur_byte;
                        push_start = 1'b1;
                        type_next  = cur_byte[4:0];
                        state_next = ST_PAYLOAD;
                    end
                    ST_PAYLOAD: begin
`ifdef H264_NAL_EPB_STRIP_EN
                        if (cur_byte == 8'h03 && zero_run_reg == 2'd2) begin
                            zero_run_next = 2'd0;
                            rel_next      = (held_reg != 2'd0);
                        end else
`endif
                        if (cur_byte == 8'h00) begin
                            if (held_reg != 2'd3) held_next = held_reg + 2'd1;
                        end else if (held_reg == 2'd0) begin
                            do_push   = 1'b1;
                            push_byte = cur_byte;
                        end else begin
                            pend_valid_next = 1'b1;
                            pend_byte_next  = cur_byte;
                            rel_next        = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        out_valid_next  = out_valid_reg && !BYTE_READY_I;
        out_byte_next   = out_byte_reg;
        out_start_next  = out_start_reg;
        out_end_next    = out_end_reg;
        last_valid_next = last_valid_reg;
        last_byte_next  = last_byte_reg;
        last_start_next = last_start_reg;
        if (do_push) begin
            if (last_valid_reg) begin
                out_valid_next = 1'b1;
                out_byte_next  = last_byte_reg;
                out_start_next = last_start_reg;
                out_end_next   = 1'b0;
            end
            last_valid_next = 1'b1;
            last_byte_next  = push_byte;
            last_start_next = push_start;
        end else if (do_term && last_valid_reg) begin
            out_valid_next  = 1'b1;
            out_byte_next   = last_byte_reg;
            out_start_next  = last_start_reg;
            out_end_next    = 1'b1;
            last_valid_next = 1'b0;
        end
    end

    // datapath registers and completed-NAL counter
    always_ff @(posedge PIX_CLK) begin
        if (!RESET_N) begin
            zero_run_reg   <= 2'd0;
            held_reg       <= 2'd0;
            rel_reg        <= 1'b0;
            pend_valid_reg <= 1'b0;
            pend_byte_reg  <= 8'h00;
            last_valid_reg <= 1'b0;
            last_byte_reg  <= 8'h00;
            last_start_reg <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_byte_reg   <= 8'h00;
            out_start_reg  <= 1'b0;
            out_end_reg    <= 1'b0;
            type_reg       <= 5'd0;
            count_reg      <= '0;
        end else begin
            zero_run_reg   <= zero_run_next;
            held_reg       <= held_next;
            rel_reg        <= rel_next;
            pend_valid_reg <= pend_valid_next;
            pend_byte_reg  <= pend_byte_next;
            last_valid_reg <= last_valid_next;
            last_byte_reg  <= last_byte_next;
            last_start_reg <= last_start_next;
            out_valid_reg  <= out_valid_next;
            out_byte_reg   <= out_byte_next;
            out_start_reg  <= out_start_next;
            out_end_reg    <= out_end_next;
            type_reg       <= type_next;
            if (out_valid_reg && BYTE_READY_I && out_end_reg)
                count_reg <= count_reg + CNT_ONE;
        end
    end

    assign BYTE_VALID_O = out_valid_reg;
    assign BYTE_O       = out_byte_reg;
    assign NAL_START_O  = out_start_reg;
    assign NAL_END_O    = out_end_reg;
    assign NAL_TYPE_O   = type_reg;
    assign NAL_COUNT_O  = count_reg;
    assign OVERFLOW_O   = overflow_reg;
endmodule

// File: tb/tb_h264_nal_parser.sv
// Scoreboard bench for h264_nal_parser: directed word streams push expected
// NAL bytes into a queue; a monitor pops and compares every accepted byte.
module tb_h264_nal_parser;
    logic        PIX_CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        DATA_VALID_I = 1'b0;
    logic [15:0] DATA_I = 16'h0000;
    logic        FLUSH_I = 1'b0;
    logic        BYTE_READY_I = 1'b1;
    logic        BYTE_VALID_O;
    logic [7:0]  BYTE_O;
    logic        NAL_START_O;
    logic        NAL_END_O;
    logic [4:0]  NAL_TYPE_O;
    logic [15:0] NAL_COUNT_O;
    logic        OVERFLOW_O;

    h264_nal_parser #(.g_FIFO_AW(4), .g_CNT_W(16)) dut (
        .PIX_CLK(PIX_CLK), .RESET_N(RESET_N),
        .DATA_VALID_I(DATA_VALID_I), .DATA_I(DATA_I), .FLUSH_I(FLUSH_I),
        .BYTE_READY_I(BYTE_READY_I), .BYTE_VALID_O(BYTE_VALID_O), .BYTE_O(BYTE_O),
        .NAL_START_O(NAL_START_O), .NAL_END_O(NAL_END_O), .NAL_TYPE_O(NAL_TYPE_O),
        .NAL_COUNT_O(NAL_COUNT_O), .OVERFLOW_O(OVERFLOW_O)
    );

    always #5 PIX_CLK = ~PIX_CLK;

    typedef struct packed {
        logic [7:0] b;
        logic       s;
        logic       e;
        logic [4:0] t;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic expect_byte(input logic [7:0] b, input logic s, input logic e, input logic [4:0] t);
        exp_t x;
        x.b = b; x.s = s; x.e = e; x.t = t;
        exp_q.push_back(x);
    endtask

    // monitor: one comparison set per accepted byte, sampled mid-cycle
    always @(negedge PIX_CLK) begin
        if (RESET_N && BYTE_VALID_O && BYTE_READY_I) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", {24'd0, BYTE_O}, 32'hFFFF_FFFF);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                chk("byte", {24'd0, BYTE_O}, {24'd0, x.b});
                chk("nal_start", {31'd0, NAL_START_O}, {31'd0, x.s});
                chk("nal_end", {31'd0, NAL_END_O}, {31'd0, x.e});
                if (x.s) chk("nal_type", {27'd0, NAL_TYPE_O}, {27'd0, x.t});
            end
        end
    end

    task automatic put_word(input logic [15:0] w);
        DATA_VALID_I = 1'b1;
        DATA_I = w;
        @(posedge PIX_CLK); #1;
        DATA_VALID_I = 1'b0;
    endtask

    task automatic put_flush();
        FLUSH_I = 1'b1;
        @(posedge PIX_CLK); #1;
        FLUSH_I = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge PIX_CLK); #1;
        end
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || BYTE_VALID_O) && cyc < 300) begin
            @(posedge PIX_CLK); #1;
            cyc++;
        end
        idle(2);
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string name);
        chk({name, "_valid"}, {31'd0, BYTE_VALID_O}, 0);
        chk({name, "_byte"}, {24'd0, BYTE_O}, 0);
        chk({name, "_start"}, {31'd0, NAL_START_O}, 0);
        chk({name, "_end"}, {31'd0, NAL_END_O}, 0);
        chk({name, "_type"}, {27'd0, NAL_TYPE_O}, 0);
        chk({name, "_count"}, {16'd0, NAL_COUNT_O}, 0);
        chk({name, "_overflow"}, {31'd0, OVERFLOW_O}, 0);
    endtask

    task automatic pulse_reset();
        RESET_N = 1'b0;
        @(posedge PIX_CLK); #1;
        RESET_N = 1'b1;
    endtask

    initial begin
        logic [7:0] hi;
        // reset state
        idle(3);
        check_reset_values("reset");
        RESET_N = 1'b1;
        idle(2);

        // single NAL, trailing zero dropped at flush
        expect_byte(8'h67, 1'b1, 1'b0, 5'd7);
        expect_byte(8'h4D, 1'b0, 1'b1, 5'd7);
        put_word(16'h0000); put_word(16'h0167); put_word(16'h4D00); put_flush();
        wait_drain("sps");
        chk("count_sps", {16'd0, NAL_COUNT_O}, 1);

        // two NALs separated by 4-byte start code with trailing zeros
        expect_byte(8'h65, 1'b1, 1'b0, 5'd5);
        expect_byte(8'hAA, 1'b0, 1'b1, 5'd5);
        expect_byte(8'h68, 1'b1, 1'b0, 5'd8);
        expect_byte(8'h12, 1'b0, 1'b0, 5'd8);
        expect_byte(8'h34, 1'b0, 1'b1, 5'd8);
        put_word(16'h0000); put_word(16'h0165); put_word(16'hAA00);
        put_word(16'h0000); put_word(16'h0168); put_word(16'h1234); put_flush();
        wait_drain("two_nal");
        chk("count_two_nal", {16'd0, NAL_COUNT_O}, 3);

        // emulation-prevention byte handling
        expect_byte(8'h41, 1'b1, 1'b0, 5'd1);
        expect_byte(8'h00, 1'b0, 1'b0, 5'd1);
        expect_byte(8'h00, 1'b0, 1'b0, 5'd1);
`ifndef H264_NAL_EPB_STRIP_EN
        expect_byte(8'h03, 1'b0, 1'b0, 5'd1);
`endif
        expect_byte(8'h01, 1'b0, 1'b1, 5'd1);
        put_word(16'h0000); put_word(16'h0141); put_word(16'h0000); put_word(16'h0301);
        put_flush();
        wait_drain("epb");
        chk("count_epb", {16'd0, NAL_COUNT_O}, 4);

        // backpressure and overflow: stall the pipeline, then 20 more words
        pulse_reset();
        idle(1);
        BYTE_READY_I = 1'b0;
        expect_byte(8'h67, 1'b1, 1'b0, 5'd7);
        expect_byte(8'hA1, 1'b0, 1'b0, 5'd7);
        expect_byte(8'hA2, 1'b0, 1'b0, 5'd7);
        put_word(16'h0000); put_word(16'h0167); put_word(16'hA1A2);
        idle(10);
        chk("stall_no_overflow", {31'd0, OVERFLOW_O}, 0);
        for (int i = 0; i < 20; i++) begin
            hi = 8'h10 + 8'(2 * i);
            if (i < 16) begin
                expect_byte(hi, 1'b0, 1'b0, 5'd7);
                expect_byte(hi + 8'h01, 1'b0, (i == 15), 5'd7);
            end
            put_word({hi, hi + 8'h01});
            if (i == 15) chk("overflow_after_16", {31'd0, OVERFLOW_O}, 0);
            if (i == 16) chk("overflow_after_17", {31'd0, OVERFLOW_O}, 1);
        end
        idle(7);
        chk("stall_valid", {31'd0, BYTE_VALID_O}, 1);
        chk("stall_byte", {24'd0, BYTE_O}, 32'h67);
        chk("stall_start", {31'd0, NAL_START_O}, 1);
        BYTE_READY_I = 1'b1;
        idle(5);
        put_flush();
        wait_drain("overflow");
        chk("overflow_sticky", {31'd0, OVERFLOW_O}, 1);
        chk("count_overflow", {16'd0, NAL_COUNT_O}, 1);

        // reset in the middle of a payload
        expect_byte(8'h65, 1'b1, 1'b0, 5'd5);
        expect_byte(8'h11, 1'b0, 1'b0, 5'd5);
        put_word(16'h0000); put_word(16'h0165); put_word(16'h1122);
        idle(10);
        pulse_reset();
        check_reset_values("midreset");
        expect_byte(8'h06, 1'b1, 1'b0, 5'd6);
        expect_byte(8'h77, 1'b0, 1'b0, 5'd6);
        expect_byte(8'h88, 1'b0, 1'b1, 5'd6);
        put_word(16'h0000); put_word(16'h0106); put_word(16'h7788); put_flush();
        wait_drain("after_reset");
        chk("count_after_reset", {16'd0, NAL_COUNT_O}, 1);

        idle(5);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/h264_nal_parser.md
H264_NAL_PARSER -- requirements
Module: h264_nal_parser

Interface
REQ-001 SHALL have parameter g_FIFO_AW, default 4, meaning input FIFO address width (depth 2**g_FIFO_AW entries).
REQ-002 SHALL have parameter g_CNT_W, default 16, meaning NAL_COUNT_O width.
REQ-003 PIX_CLK  in  1  sole clock; all logic on rising edge.
REQ-004 RESET_N  in  1  reset, synchronous, active-low.
REQ-005 DATA_VALID_I  in  1  16-bit encoder output word valid; no backpressure toward encoder.
REQ-006 DATA_I  in  16  encoder Annex-B byte stream; DATA_I[15:8] is the earlier byte, DATA_I[7:0] the later.
REQ-007 FLUSH_I  in  1  end-of-stream pulse; ordered after any word written in the same cycle.
REQ-008 BYTE_READY_I  in  1  downstream accepts BYTE_O.
REQ-009 BYTE_VALID_O  out  1  BYTE_O valid.
REQ-010 BYTE_O  out  8  NAL byte, start codes removed.
REQ-011 NAL_START_O  out  1  BYTE_O is the NAL header byte.
REQ-012 NAL_END_O  out  1  BYTE_O is the last byte of its NAL.
REQ-013 NAL_TYPE_O  out  5  nal_unit_type of current NAL.
REQ-014 NAL_COUNT_O  out  g_CNT_W  completed NALs; wraps at 2**g_CNT_W.
REQ-015 OVERFLOW_O  out  1  sticky input-FIFO overflow.

Function
REQ-016 Input FIFO entry = {has_data, flush, data[15:0]}; written when DATA_VALID_I or FLUSH_I is 1.
REQ-017 FIFO full at write: entry dropped, OVERFLOW_O set to 1; simultaneous read frees no space for that write.
REQ-018 Unpacker feeds the detector one byte per enabled cycle, [15:8] then [7:0]; flush marker acted on after both bytes of its entry.
REQ-019 Detector enabled only when output register free or BYTE_READY_I=1, and no held zeros pending release.
REQ-020 States: HUNT (discard bytes), HEADER, PAYLOAD; reset state HUNT.
REQ-021 zero_run counter saturates at 3; reset to 0 by any non-zero byte.
REQ-022 Start code = byte 0x01 with zero_run>=2, in any state -> HEADER; zero_run cleared.
REQ-023 PAYLOAD 0x00 bytes held (count only, max 3), not emitted immediately.
REQ-024 PAYLOAD non-start-code byte: held zeros released one per cycle, then that byte.
REQ-025 On start code, flush marker in PAYLOAD, or flush in HEADER: held zeros discarded (trailing_zero_8bits).
REQ-026 A one-byte last-byte register delays every NAL byte by one payload byte; the byte is released with NAL_END_O=1 on start code or flush, otherwise with NAL_END_O=0.
REQ-027 HEADER byte: emitted with NAL_START_O=1, NAL_TYPE_O<=byte[4:0], -> PAYLOAD; a one-byte NAL carries NAL_START_O=NAL_END_O=1.
REQ-028 NAL_COUNT_O increments in the cycle a NAL_END_O byte is accepted.
REQ-029 Flush marker: NAL terminated per REQ-025/026, -> HUNT, zero_run cleared.
REQ-030 BYTE_O, NAL_START_O, NAL_END_O held stable while BYTE_VALID_O=1 and BYTE_READY_I=0.
REQ-031 Throughput: 1 byte/cycle when BYTE_READY_I=1; the ready path carries no combinational loop.

Reset
REQ-032 RESET_N=0 at a PIX_CLK edge: FIFO empty, state HUNT, zero_run 0, held zeros 0, last-byte register empty, BYTE_VALID_O 0, NAL_START_O 0, NAL_END_O 0, BYTE_O 0, NAL_TYPE_O 0, NAL_COUNT_O 0, OVERFLOW_O 0.
REQ-033 Reset mid-NAL discards all buffered bytes; no NAL_END_O is emitted for the truncated NAL.

Configuration
REQ-034 H264_NAL_EPB_STRIP_EN defined: PAYLOAD byte 0x03 with zero_run==2 dropped (held zeros released), zero_run cleared.
REQ-035 H264_NAL_EPB_STRIP_EN undefined: 0x03 treated as an ordinary payload byte.

Verification
REQ-036 Words 0x0000,0x0167,0x4D00 then FLUSH_I, ready=1 -> bytes 0x67(START, type 7), 0x4D(END); held 0x00 discarded; NAL_COUNT_O=1.
REQ-037 Words 0x0000,0x0165,0xAA00,0x0000,0x0168,0x1234 then FLUSH_I -> NAL1: 0x65 START, 0xAA END; NAL2: 0x68 START, 0x12, 0x34 END; count 2.
REQ-038 With EN defined, payload 0x00,0x00,0x03,0x01 -> 0x00,0x00,0x01; undefined -> 0x00,0x00,0x03,0x01.
REQ-039 BYTE_READY_I=0 for 40 cycles while 20 words written, g_FIFO_AW=4 -> OVERFLOW_O=1 after the 17th write, first 16 words emitted intact.
REQ-040 RESET_N=0 one cycle mid-payload -> outputs at reset values; next start code parsed normally; NAL_COUNT_O restarts at 0.
